// File: rtl/intercal_alu_sequencer.sv
// intercal_alu_sequencer
//   Byte-stream command front end for the INTERCAL ALU core. An opcode byte
//   followed by little-endian operand bytes arrives on a valid/ready input
//   stream. The assembled opcode and operands are held steady on the ALU
//   inputs, the combinational ALU result is captured in a single execute
//   cycle, and the 32-bit result then leaves as four bytes (LSB first) on a
//   valid/ready output stream.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    command/operand byte           in_valid / in_ready handshake
//   out_data   result byte                    out_valid / out_ready handshake
//   alu_op     registered opcode to the ALU
//   alu_a      registered operand A to the ALU
//   alu_b      registered operand B to the ALU
//   alu_f      combinational ALU result
//   busy       high whenever a command is in progress
module intercal_alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_f,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_SEND   = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  idx;
  logic        unary;
  logic [31:0] result;
  logic        in_xfer;
  logic        out_xfer;

  // Replace byte sel (0 = bits 7:0) of word with b.
  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  sel,
                                           input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    case (sel)
      2'd0:    w[7:0]   = b;
      2'd1:    w[15:8]  = b;
      2'd2:    w[23:16] = b;
      default: w[31:24] = b;
    endcase
    return w;
  endfunction

  // Extract byte sel (0 = bits 7:0) of word.
  function automatic logic [7:0] get_byte(input logic [31:0] word,
                                          input logic [1:0]  sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

  assign in_ready  = (state == S_IDLE) || (state == S_LOAD_A) || (state == S_LOAD_B);
  assign out_valid = (state == S_SEND);
  assign busy      = (state != S_IDLE);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  // result is zero after reset, so out_data reads 0x00 then as well.
  assign out_data  = get_byte(result, idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= 2'd0;
      unary  <= 1'b0;
      alu_op <= 4'd0;
      alu_a  <= 32'd0;
      alu_b  <= 32'd0;
      result <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_xfer) begin
            alu_op <= in_data[3:0];
            unary  <= in_data[4];
            idx    <= 2'd0;
            // REPEAT reuses the held operands; UNARY is then irrelevant.
            state  <= in_data[5] ? S_EXEC : S_LOAD_A;
          end
        end
        S_LOAD_A: begin
          if (in_xfer) begin
            alu_a <= put_byte(alu_a, idx, in_data);
            idx   <= idx + 2'd1;
            if (idx == 2'd3) state <= unary ? S_EXEC : S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (in_xfer) begin
            alu_b <= put_byte(alu_b, idx, in_data);
            idx   <= idx + 2'd1;
            if (idx == 2'd3) state <= S_EXEC;
          end
        end
        S_EXEC: begin
          result <= alu_f;
          idx    <= 2'd0;
          state  <= S_SEND;
        end
        S_SEND: begin
          if (out_xfer) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          idx   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intercal_alu_sequencer.sv
module tb_intercal_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_f;
  logic        busy;

  logic        xor_mode;

  int tests;
  int fails;

  // Reference model state: what the ALU inputs should hold.
  logic [3:0]  m_op;
  logic [31:0] m_a;
  logic [31:0] m_b;

  intercal_alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .busy(busy)
  );

  // ALU stub.
  assign alu_f = xor_mode ? (alu_a ^ alu_b) : (alu_a + alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one byte after `gap` idle cycles; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    logic [31:0] a0;
    a0 = alu_a;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check("stall_hold_a", alu_a, a0);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // Collect four result bytes with `bp` cycles of out_ready low before each.
  task automatic recv_word(input logic [31:0] exp, input int bp);
    int n;
    logic [31:0] e;
    e = exp;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      for (int k = 0; k < bp; k++) begin
        out_ready = 1'b0;
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_data", {24'd0, out_data}, {24'd0, e[7:0]});
        @(negedge clk);
      end
      out_ready = 1'b1;
      n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("out_byte", {24'd0, out_data}, {24'd0, e[7:0]});
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      e = e >> 8;
    end
    check("busy_after", {31'd0, busy}, 32'd0);
    check("in_ready_after", {31'd0, in_ready}, 32'd1);
    check("out_valid_after", {31'd0, out_valid}, 32'd0);
  endtask

  // One full command: opcode, operands as required by its flags, result.
  task automatic do_cmd(input logic [7:0] opc, input logic [31:0] a,
                        input logic [31:0] b, input int gap, input int bp);
    logic [31:0] exp;
    int nin;
    nin = 1;
    send_byte(opc, gap);
    m_op = opc[3:0];
    if (!opc[5]) begin
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], gap);
      m_a = a;
      nin += 4;
      if (!opc[4]) begin
        for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8], gap);
        m_b = b;
        nin += 4;
      end
    end
    // Now in the execute cycle.
    check("exec_in_ready", {31'd0, in_ready}, 32'd0);
    check("exec_out_valid", {31'd0, out_valid}, 32'd0);
    check("exec_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("send_out_valid", {31'd0, out_valid}, 32'd1);
    check("alu_op", {28'd0, alu_op}, {28'd0, m_op});
    check("alu_a", alu_a, m_a);
    check("alu_b", alu_b, m_b);
    exp = xor_mode ? (m_a ^ m_b) : (m_a + m_b);
    recv_word(exp, bp);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    xor_mode  = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    m_op = 4'd0; m_a = 32'd0; m_b = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full load, add stub.
    do_cmd(8'h03, 32'h12345678, 32'h00000001, 0, 0);
    check("full_a", alu_a, 32'h12345678);

    // Unary: only A is reloaded.
    do_cmd(8'h15, 32'h000000FF, 32'hDEADBEEF, 0, 0);
    check("unary_b_kept", alu_b, 32'h00000001);

    // Repeat with xor stub: out_valid one cycle after the opcode edge.
    xor_mode = 1'b1;
    send_byte(8'h27, 0);
    m_op = 4'd7;
    check("rep_exec_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("rep_valid", {31'd0, out_valid}, 32'd1);
    check("rep_op", {28'd0, alu_op}, 32'd7);
    recv_word(32'h000000FE, 0);

    // Backpressure with input noise during SEND.
    xor_mode = 1'b0;
    send_byte(8'h02, 0);
    m_op = 4'd2;
    for (int i = 0; i < 4; i++) send_byte(8'h11 * (i + 1), 0);
    for (int i = 0; i < 4; i++) send_byte(8'h01, 0);
    m_a = 32'h44332211;
    m_b = 32'h01010101;
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = $urandom_range(0, 1);
      in_data  = 8'($urandom);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_byte0", {24'd0, out_data}, 32'h00000012);
      check("bp_hold_a", alu_a, m_a);
      check("bp_hold_b", alu_b, m_b);
    end
    @(negedge clk);
    in_valid = 1'b0;
    recv_word(32'h45342312, 0);

    // Reset mid-load, asynchronously between edges.
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2;
    rst_n = 1'b0;
    #1;
    m_op = 4'd0; m_a = 32'd0; m_b = 32'd0;
    check("mid_rst_a", alu_a, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // First byte after release is an opcode (repeat, op 4).
    do_cmd(8'h24, 32'd0, 32'd0, 0, 0);

    // Stalled input reproduces the zero-stall result.
    do_cmd(8'h03, 32'h12345678, 32'h00000001, 2, 1);

    // Randomized commands against the model.
    for (int t = 0; t < 25; t++) begin
      logic [7:0]  opc;
      logic [31:0] ra, rb;
      opc = 8'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      xor_mode = $urandom_range(0, 1);
      do_cmd(opc, ra, rb, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
